instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction fetch and issue unit that feeds the CPU control FSM. It holds a small program memory written through a load port. After `start`, it presents instructions on `instruction` and advances the program counter on each `done` pulse from the control FSM, until it reaches a HALT word or is stopped. It sits between the program-load logic (or testbench) and the control FSM's `instruction`/`done` pair.

## Interface
- `OP_SIZE`, default 4: opcode width.
- `ARG_SIZE`, default 3: width of each register argument.
- `ARG_NUM`, default 2: number of arguments; `INSTR_W = OP_SIZE + ARG_NUM*ARG_SIZE` (10 by default).
- `ADDR_W`, default 4: program address width; `DEPTH = 2**ADDR_W` words.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  write strobe for program memory.
- `load_addr`  in  ADDR_W  write address.
- `load_data`  in  INSTR_W  instruction word to write.
- `start`  in  1  begin execution at address 0.
- `stop`  in  1  request stop after the instruction currently in flight.
- `done`  in  1  instruction-complete pulse from the control FSM.
- `instruction`  out  INSTR_W  instruction presented to the control FSM (combinational).
- `pc`  out  ADDR_W  current program counter.
- `retired`  out  8  count of instructions completed since the last start.
- `busy`  out  1  high in RUN.
- `halted`  out  1  high in HALTED.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- Opcodes: LOAD 4'b0000, MOVE 4'b0001, ADD 4'b0010, XOR 4'b0011.
- HALT/NOP opcode is 4'b1111; the canonical word is {4'b1111, 0…} = 10'h3C0. The control FSM treats any other opcode as idle.
- States:
  - IDLE → RUN on `start` (pc←0, retired←0, stop_pending←0).
  - RUN → HALTED on HALT detection.
  - RUN → IDLE on `done` with stop_pending set.
  - HALTED → RUN on `start` (same clears as from IDLE).
- `instruction` output:
  - IDLE or HALTED: NOP word.
  - RUN with `done`=0: mem[pc].
  - RUN with `done`=1: lookahead word mem[pc+1 mod DEPTH], or NOP if stop_pending. This lets the control FSM select its next state from the next instruction in the same cycle.
- On `done`=1 in RUN:
  - pc←pc+1, wrapping DEPTH-1 → 0.
  - retired←retired+1, wrapping 255 → 0.
  - If stop_pending: go to IDLE.
  - Else if the lookahead opcode is HALT: go to HALTED.
- In RUN with `done`=0, if mem[pc]'s opcode is HALT (program starts with HALT, or pc wrapped onto one): go to HALTED on the next edge; pc is unchanged.
- `stop`:
  - Sets stop_pending in RUN; ignored in IDLE/HALTED.
  - `stop` and `done` in the same cycle: stop takes effect at that done (NOP is presented, go to IDLE).
- `done` outside RUN is ignored; pc and retired hold.
- `start` in RUN is ignored.
- `load_en`:
  - Accepted in IDLE/HALTED: mem[load_addr]←load_data on the edge.
  - In RUN: the write is dropped and `load_err` pulses high for exactly the following cycle.
  - A load in the same cycle as `start` from IDLE is accepted; execution begins next cycle and sees the new word.

## Timing
- Reset (async, `rst`=0):
  - state IDLE, pc 0, retired 0, stop_pending 0.
  - busy 0, halted 0, load_err 0.
  - `instruction` = 10'h3C0.
  - All DEPTH memory words = 10'h3C0.
- `start` sampled at edge N: busy=1 and `instruction`=mem[0] from cycle N+1; the control FSM leaves its idle state at edge N+1.
- pc, retired and state all update on the same edge that samples `done`.
- `instruction` has zero-cycle combinational dependence on `done` and registered pc; there is no combinational path from `instruction` back to `done` in this block.
- Load-to-run latency: a word written at edge N is visible to a start at edge N or later.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst`=0, release, wait 5 cycles.
  - Required: `instruction`=10'h3C0, pc=0, retired=0, busy=halted=load_err=0.
- Program run:
  - Stimulus: load mem[0]=10'h008 (LOAD R1), mem[1]=10'h08A (ADD R1,R2), mem[2]=10'h3C0; pulse start; model `done` 2 cycles after issue for LOAD and 3 cycles for ADD.
  - Required: `instruction` shows 10'h008 then 10'h08A (during the LOAD done cycle); ends halted=1, pc=2, retired=2, `instruction`=10'h3C0.
- Stop mid-program:
  - Stimulus: 4 LOAD words, then pulse `stop` during instruction 1.
  - Required: during instruction 1's done cycle `instruction`=NOP; next cycle busy=0, halted=0, pc=2, retired=2.
- Load during run:
  - Stimulus: `load_en` while busy.
  - Required: `load_err`=1 for exactly one cycle; memory unchanged (a rerun shows the original word).
- Wrap and immediate halt:
  - Stimulus: all 16 words LOAD, run 17 dones; separately, mem[0]=10'h3C0 then start.
  - Required: pc wraps to 0 and then 1, retired=17; the HALT-first program gives halted=1 one cycle after RUN entry, with pc=0 and retired=0.
- Async reset mid-instruction:
  - Stimulus: assert `rst` between edges while busy.
  - Required: all outputs reach reset values immediately, without waiting for a clock edge; memory returns to 10'h3C0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction fetch/issue unit: small program memory with a load port, a program
// counter advanced by the control FSM's done pulse, and a same-cycle lookahead word.
module instr_sequencer #(
    parameter  int OP_SIZE  = 4,
    parameter  int ARG_SIZE = 3,
    parameter  int ARG_NUM  = 2,
    parameter  int ADDR_W   = 4,
    localparam int INSTR_W  = OP_SIZE + ARG_NUM * ARG_SIZE,
    localparam int DEPTH    = 2 ** ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic               stop,
    input  logic               done,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic [7:0]         retired,
    output logic               busy,
    output logic               halted,
    output logic               load_err
);

    localparam logic [OP_SIZE-1:0] HALT_OP  = '1;
    localparam logic [INSTR_W-1:0] NOP_WORD = {HALT_OP, {(INSTR_W - OP_SIZE){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [7:0]          r_retired;
    logic [7:0]          w_retired_nxt;
    logic                r_stop_pending;
    logic                w_stop_pending_nxt;
    logic                r_load_err;
    logic [INSTR_W-1:0]  r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_pc_inc;
    logic [INSTR_W-1:0]  w_cur_word;
    logic [INSTR_W-1:0]  w_next_word;
    logic                w_cur_halt;
    logic                w_next_halt;
    logic                w_stop_now;
    logic                w_running;
    logic                w_load_ok;

    assign w_running   = (r_state == S_RUN);
    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_cur_word  = r_mem[r_pc];
    assign w_next_word = r_mem[w_pc_inc];
    assign w_cur_halt  = (w_cur_word[INSTR_W-1 -: OP_SIZE] == HALT_OP);
    assign w_next_halt = (w_next_word[INSTR_W-1 -: OP_SIZE] == HALT_OP);
    // A stop arriving together with done still retires that instruction, but nothing follows it.
    assign w_stop_now  = r_stop_pending | stop;
    assign w_load_ok   = load_en & ~w_running;

    // NOTE: every output of this block gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_retired_nxt      = r_retired;
        w_stop_pending_nxt = r_stop_pending;
        instruction        = NOP_WORD;

        case (r_state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    w_state_nxt        = S_RUN;
                    w_pc_nxt           = '0;
                    w_retired_nxt      = '0;
                    w_stop_pending_nxt = 1'b0;
                end
            end

            S_RUN: begin
                if (done) begin
                    w_pc_nxt      = w_pc_inc;
                    w_retired_nxt = r_retired + 8'd1;
                    instruction   = w_stop_now ? NOP_WORD : w_next_word;
                    if (w_stop_now) begin
                        w_state_nxt        = S_IDLE;
                        w_stop_pending_nxt = 1'b0;
                    end else if (w_next_halt) begin
                        w_state_nxt = S_HALTED;
                    end
                end else begin
                    instruction = w_cur_word;
                    if (w_cur_halt) begin
                        // Program started on, or wrapped onto, a HALT word.
                        w_state_nxt        = S_HALTED;
                        w_stop_pending_nxt = 1'b0;
                    end else if (stop) begin
                        w_stop_pending_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt        = S_IDLE;
                w_stop_pending_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_pc           <= '0;
            r_retired      <= '0;
            r_stop_pending <= 1'b0;
            r_load_err     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_retired      <= w_retired_nxt;
            r_stop_pending <= w_stop_pending_nxt;
            r_load_err     <= load_en & w_running;
        end
    end

    // NOTE: the program store is deliberately built from resettable flops, because
    // reset must leave every word reading as HALT; it cannot map onto a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= NOP_WORD;
            end
        end else if (w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign pc       = r_pc;
    assign retired  = r_retired;
    assign busy     = w_running;
    assign halted   = (r_state == S_HALTED);
    assign load_err = r_load_err;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus random traffic,
// compared every cycle against a behavioural program-execution model.
module tb_instr_sequencer;

    localparam logic [9:0] NOP = 10'h3C0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_addr = '0;
    logic [9:0] load_data = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       done = 1'b0;
    logic [9:0] instruction;
    logic [3:0] pc;
    logic [7:0] retired;
    logic       busy;
    logic       halted;
    logic       load_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] obs_instr;
    logic       obs_lerr;

    // Behavioural model: a program memory plus "running / halted" flags and counters.
    logic [9:0] m_mem [16];
    bit         m_busy, m_halted, m_stop, m_lerr;
    int         m_pc, m_ret;

    instr_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .stop       (stop),
        .done       (done),
        .instruction(instruction),
        .pc         (pc),
        .retired    (retired),
        .busy       (busy),
        .halted     (halted),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_halt(input logic [9:0] w);
        return w[9:6] == 4'hF;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = NOP;
        m_busy = 0; m_halted = 0; m_stop = 0; m_lerr = 0;
        m_pc = 0; m_ret = 0;
    endtask

    // What the control FSM should see before the coming edge.
    function automatic logic [9:0] model_instr(input bit d, input bit s);
        if (!m_busy) return NOP;
        if (!d) return m_mem[m_pc];
        if (m_stop || s) return NOP;
        return m_mem[(m_pc + 1) % 16];
    endfunction

    task automatic model_edge(input bit ld, input logic [3:0] la, input logic [9:0] ldat,
                              input bit st, input bit sp, input bit d);
        logic [9:0] nxt;
        m_lerr = m_busy && ld;
        if (!m_busy) begin
            if (ld) m_mem[la] = ldat;
            if (st) begin
                m_busy = 1; m_halted = 0; m_stop = 0; m_pc = 0; m_ret = 0;
            end
        end else if (d) begin
            nxt   = m_mem[(m_pc + 1) % 16];
            m_pc  = (m_pc + 1) % 16;
            m_ret = (m_ret + 1) % 256;
            if (m_stop || sp) begin
                m_busy = 0; m_stop = 0;
            end else if (is_halt(nxt)) begin
                m_busy = 0; m_halted = 1;
            end
        end else if (is_halt(m_mem[m_pc])) begin
            m_busy = 0; m_halted = 1; m_stop = 0;
        end else if (sp) begin
            m_stop = 1;
        end
    endtask

    task automatic compare_all(input string tag, input bit d, input bit s);
        check({tag, ".instr"},   instruction, model_instr(d, s));
        check({tag, ".pc"},      pc,          m_pc[3:0]);
        check({tag, ".retired"}, retired,     m_ret[7:0]);
        check({tag, ".busy"},    busy,        m_busy);
        check({tag, ".halted"},  halted,      m_halted);
        check({tag, ".lerr"},    load_err,    m_lerr);
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic cyc(input string tag, input bit ld, input logic [3:0] la, input logic [9:0] ldat,
                       input bit st, input bit sp, input bit d);
        load_en = ld; load_addr = la; load_data = ldat;
        start = st; stop = sp; done = d;
        #1;
        obs_instr = instruction;
        obs_lerr  = load_err;
        compare_all(tag, d, sp);
        @(posedge clk);
        model_edge(ld, la, ldat, st, sp, d);
        @(negedge clk);
        load_en = 0; start = 0; stop = 0; done = 0;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [9:0] w);
        cyc("load", 1, a, w, 0, 0, 0);
    endtask

    // Plays the control FSM: LOAD takes 2 cycles, ADD 3, anything else 1.
    task automatic run_prog(input string tag, input int budget);
        int age = 0;
        int lat;
        for (int c = 0; c < budget && m_busy; c++) begin
            case (m_mem[m_pc][9:6])
                4'h0:    lat = 2;
                4'h2:    lat = 3;
                default: lat = 1;
            endcase
            age++;
            if (age >= lat) begin
                cyc(tag, 0, 0, 0, 0, 0, 1);
                age = 0;
            end else begin
                cyc(tag, 0, 0, 0, 0, 0, 0);
            end
        end
        check({tag, ".budget"}, busy, 1'b0);
    endtask

    function automatic logic [9:0] rand_word();
        logic [3:0] op;
        op = ($urandom_range(0, 99) < 15) ? 4'hF : 4'($urandom_range(0, 3));
        return {op, 6'($urandom_range(0, 63))};
    endfunction

    initial begin
        model_reset();
        #1;
        compare_all("in_reset", 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;

        // Reset then idle.
        for (int i = 0; i < 5; i++) cyc("idle", 0, 0, 0, 0, 0, 0);
        check("idle.instr", instruction, NOP);
        check("idle.pc", pc, 4'd0);

        // Program run: LOAD R1, ADD R1,R2, HALT.
        load_word(4'd0, 10'h008);
        load_word(4'd1, 10'h08A);
        load_word(4'd2, 10'h3C0);
        cyc("prog_start", 0, 0, 0, 1, 0, 0);
        cyc("prog_i0", 0, 0, 0, 0, 0, 0);
        check("prog.first", obs_instr, 10'h008);
        cyc("prog_d0", 0, 0, 0, 0, 0, 1);
        check("prog.lookahead", obs_instr, 10'h08A);
        run_prog("prog", 20);
        check("prog.halted", halted, 1'b1);
        check("prog.pc", pc, 4'd2);
        check("prog.retired", retired, 8'd2);
        check("prog.instr", instruction, NOP);

        // Stop mid-program.
        for (int i = 0; i < 4; i++) load_word(4'(i), 10'(8 * (i + 1)));
        cyc("stop_start", 0, 0, 0, 1, 0, 0);
        cyc("stop_d0", 0, 0, 0, 0, 0, 1);
        cyc("stop_req", 0, 0, 0, 0, 1, 0);
        cyc("stop_d1", 0, 0, 0, 0, 0, 1);
        check("stop.nop", obs_instr, NOP);
        check("stop.busy", busy, 1'b0);
        check("stop.halted", halted, 1'b0);
        check("stop.pc", pc, 4'd2);
        check("stop.retired", retired, 8'd2);

        // Load during run is rejected.
        load_word(4'd2, NOP);
        cyc("lrun_start", 0, 0, 0, 1, 0, 0);
        cyc("lrun_ld", 1, 4'd0, 10'h0CA, 0, 0, 0);
        cyc("lrun_p1", 0, 0, 0, 0, 0, 0);
        check("lrun.err_hi", obs_lerr, 1'b1);
        cyc("lrun_p2", 0, 0, 0, 0, 0, 0);
        check("lrun.err_lo", obs_lerr, 1'b0);
        run_prog("lrun", 20);
        cyc("lrun_restart", 0, 0, 0, 1, 0, 0);
        cyc("lrun_reread", 0, 0, 0, 0, 0, 0);
        check("lrun.mem_kept", obs_instr, 10'h008);
        run_prog("lrun2", 20);

        // Wrap: 16 LOADs, 17 dones (the last with stop).
        for (int i = 0; i < 16; i++) load_word(4'(i), {4'h0, 3'(i), 3'b000});
        cyc("wrap_start", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) cyc("wrap", 0, 0, 0, 0, 0, 1);
        check("wrap.pc0", pc, 4'd0);
        cyc("wrap_last", 0, 0, 0, 0, 1, 1);
        check("wrap.pc1", pc, 4'd1);
        check("wrap.retired", retired, 8'd17);

        // Immediate halt on a HALT-first program.
        load_word(4'd0, NOP);
        cyc("hfirst_start", 0, 0, 0, 1, 0, 0);
        check("hfirst.busy", busy, 1'b1);
        cyc("hfirst_run", 0, 0, 0, 0, 0, 0);
        check("hfirst.halted", halted, 1'b1);
        check("hfirst.pc", pc, 4'd0);
        check("hfirst.retired", retired, 8'd0);

        // Async reset mid-instruction.
        load_word(4'd0, 10'h008);
        load_word(4'd1, 10'h010);
        cyc("arst_start", 0, 0, 0, 1, 0, 0);
        cyc("arst_d0", 0, 0, 0, 0, 0, 1);
        #2;
        rst = 0;
        #1;
        model_reset();
        compare_all("arst", 0, 0);
        @(negedge clk);
        rst = 1;
        cyc("arst_restart", 0, 0, 0, 1, 0, 0);
        cyc("arst_mem", 0, 0, 0, 0, 0, 0);
        check("arst.mem_cleared", obs_instr, NOP);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit       ld, st, sp, d;
            ld = ($urandom_range(0, 99) < 12);
            st = ($urandom_range(0, 99) < 6);
            sp = ($urandom_range(0, 99) < 3);
            d  = ($urandom_range(0, 99) < 40);
            cyc("rand", ld, 4'($urandom_range(0, 15)), rand_word(), st, sp, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
